// File: rtl/lw_bridge_reg_pkg.sv
// Shared register map, TXSTAT bit positions and helpers for the lightweight-bridge register slave.
package lw_bridge_reg_pkg;

  // Word index decoded from avs_address[4:2].
  typedef enum logic [2:0] {
    REG_ID       = 3'd0,
    REG_SCRATCH  = 3'd1,
    REG_IRQ_PEND = 3'd2,
    REG_IRQ_EN   = 3'd3,
    REG_GP_OUT   = 3'd4,
    REG_GP_IN    = 3'd5,
    REG_TXDATA   = 3'd6,
    REG_TXSTAT   = 3'd7
  } reg_idx_e;

  localparam int TXSTAT_FULL  = 8;
  localparam int TXSTAT_EMPTY = 9;
  localparam int TXSTAT_OVF   = 16;
  localparam int TXSTAT_DERR  = 17;

  localparam logic [31:0] ID_DEFAULT = 32'h504C_4B31;

  // Byte-lane merge used by every RW register.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lw_bridge_sync_fifo.sv
// Single-clock show-ahead FIFO: power-of-2 depth, wrapping pointers and an explicit level counter.
module lw_bridge_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [LVL_W-1:0] level_reg;
  logic             wr_en;
  logic             rd_en;

  assign full     = (level_reg == LVL_W'(DEPTH));
  assign empty    = (level_reg == '0);
  assign level    = level_reg;
  assign wr_en    = push & ~full;
  assign rd_en    = pop & ~empty;
  assign overflow = push & full;
  assign head     = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/lw_bridge_reg_slave.sv
// Avalon-MM register slave behind the HPS lightweight bridge: ID/scratch/GP registers,
// edge-triggered IRQ controller and a TX FIFO drained over a valid/ready stream.
module lw_bridge_reg_slave
  import lw_bridge_reg_pkg::*;
#(
  parameter int          ADDR_W     = 18,
  parameter logic [31:0] ID_VALUE   = ID_DEFAULT,
  parameter int          NUM_IRQ    = 8,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic              clk100_clk,
  input  logic              reset_clk100_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_burstcount,
  input  logic              avs_debugaccess,
  output logic              avs_waitrequest,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  output logic              irq_o,
  input  logic [31:0]       gp_in,
  output logic [31:0]       gp_out,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic clk;
  logic srst;
  assign clk  = clk100_clk;
  assign srst = reset_clk100_reset;

  logic unused_ok;
  assign unused_ok = ^{avs_burstcount, avs_debugaccess, avs_address[1:0]};

  logic [31:0]        scratch_reg;
  logic [31:0]        gp_out_reg;
  logic [31:0]        gp_meta_reg;
  logic [31:0]        gp_sync_reg;
  logic [NUM_IRQ-1:0] pend_reg;
  logic [NUM_IRQ-1:0] en_reg;
  logic [NUM_IRQ-1:0] src_prev_reg;
  logic               irq_reg;
  logic               ovf_reg;
  logic               derr_reg;
  logic [31:0]        readdata_reg;
  logic               rdv_reg;

  logic [31:0]        fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [LVL_W-1:0]   fifo_level;
  logic               fifo_ovf;
  logic               fifo_pop;

  reg_idx_e idx;
  logic     in_map;
  logic     tx_hit;
  logic     wr_acc;
  logic     rd_acc;
  logic     illegal;

  assign idx     = reg_idx_e'(avs_address[4:2]);
  assign in_map  = (avs_address[ADDR_W-1:5] == '0);
  assign tx_hit  = in_map & (idx == REG_TXDATA);

  // Full is the registered flag, so a pop in the same cycle does not release the stall.
  assign avs_waitrequest = srst | (avs_write & tx_hit & fifo_full);
  assign wr_acc  = avs_write & ~avs_waitrequest;
  assign rd_acc  = avs_read & ~avs_write & ~avs_waitrequest;
  assign illegal = avs_read & avs_write & ~avs_waitrequest;

  logic wr_scratch, wr_pend, wr_en_sel, wr_gp, wr_tx, wr_stat;
  assign wr_scratch = wr_acc & in_map & (idx == REG_SCRATCH);
  assign wr_pend    = wr_acc & in_map & (idx == REG_IRQ_PEND);
  assign wr_en_sel  = wr_acc & in_map & (idx == REG_IRQ_EN);
  assign wr_gp      = wr_acc & in_map & (idx == REG_GP_OUT);
  assign wr_tx      = wr_acc & tx_hit;
  assign wr_stat    = wr_acc & in_map & (idx == REG_TXSTAT);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pend_next;
  logic               derr_set;
  logic               derr_next;
  logic               ovf_next;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_irq_edge
    assign rise[gi] = irq_src_i[gi] & ~src_prev_reg[gi];
  end

  // A fresh edge beats a same-cycle W1C on the same bit.
  assign pend_next = (pend_reg & ~(wr_pend ? avs_writedata[NUM_IRQ-1:0] : '0)) | rise;
  assign derr_set  = ((rd_acc | wr_acc) & ~in_map) | illegal;
  assign derr_next = derr_set | (derr_reg & ~(wr_stat & avs_writedata[TXSTAT_DERR]));
  assign ovf_next  = fifo_ovf | (ovf_reg & ~(wr_stat & avs_writedata[TXSTAT_OVF]));

  logic [31:0] rd_data;
  always_comb begin
    rd_data = '0;
    if (in_map) begin
      case (idx)
        REG_ID:       rd_data = ID_VALUE;
        REG_SCRATCH:  rd_data = scratch_reg;
        REG_IRQ_PEND: rd_data = 32'(pend_reg);
        REG_IRQ_EN:   rd_data = 32'(en_reg);
        REG_GP_OUT:   rd_data = gp_out_reg;
        REG_GP_IN:    rd_data = gp_sync_reg;
        REG_TXDATA:   rd_data = '0;
        REG_TXSTAT: begin
          rd_data[7:0]         = 8'(fifo_level);
          rd_data[TXSTAT_FULL]  = fifo_full;
          rd_data[TXSTAT_EMPTY] = fifo_empty;
          rd_data[TXSTAT_OVF]   = ovf_reg;
          rd_data[TXSTAT_DERR]  = derr_reg;
        end
        default:      rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      scratch_reg  <= '0;
      gp_out_reg   <= '0;
      gp_meta_reg  <= '0;
      gp_sync_reg  <= '0;
      pend_reg     <= '0;
      en_reg       <= '0;
      src_prev_reg <= '0;
      irq_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
      derr_reg     <= 1'b0;
      readdata_reg <= '0;
      rdv_reg      <= 1'b0;
    end else begin
      if (wr_scratch) scratch_reg <= be_merge(scratch_reg, avs_writedata, avs_byteenable);
      if (wr_gp)      gp_out_reg  <= be_merge(gp_out_reg, avs_writedata, avs_byteenable);
      if (wr_en_sel)  en_reg      <= NUM_IRQ'(be_merge(32'(en_reg), avs_writedata, avs_byteenable));
      gp_meta_reg  <= gp_in;
      gp_sync_reg  <= gp_meta_reg;
      src_prev_reg <= irq_src_i;
      pend_reg     <= pend_next;
      irq_reg      <= |(pend_reg & en_reg);
      ovf_reg      <= ovf_next;
      derr_reg     <= derr_next;
      rdv_reg      <= rd_acc;
      if (rd_acc) readdata_reg <= rd_data;
    end
  end

  lw_bridge_sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_tx_fifo (
    .clk      (clk),
    .srst     (srst),
    .push     (wr_tx),
    .push_data(avs_writedata),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (fifo_ovf)
  );

  // Outputs are forced low while reset is high, even before the first reset edge.
  assign tx_valid          = ~fifo_empty & ~srst;
  assign fifo_pop          = tx_valid & tx_ready;
  assign tx_data           = fifo_head & {32{~srst}};
  assign avs_readdatavalid = rdv_reg & ~srst;
  assign avs_readdata      = readdata_reg & {32{~srst}};
  assign irq_o             = irq_reg & ~srst;
  assign gp_out            = gp_out_reg & {32{~srst}};

endmodule

// File: tb/tb_lw_bridge_reg_slave.sv
// Scoreboard bench for lw_bridge_reg_slave: directed bus/IRQ/FIFO vectors, decoupled read and stream monitors.
module tb_lw_bridge_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_burstcount;
  logic        avs_debugaccess;
  logic        avs_waitrequest;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [7:0]  irq_src_i;
  logic        irq_o;
  logic [31:0] gp_in;
  logic [31:0] gp_out;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  lw_bridge_reg_slave dut (
    .clk100_clk        (clk),
    .reset_clk100_reset(rst),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_burstcount    (avs_burstcount),
    .avs_debugaccess   (avs_debugaccess),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .irq_src_i         (irq_src_i),
    .irq_o             (irq_o),
    .gp_in             (gp_in),
    .gp_out            (gp_out),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        rd_q[$];
  logic [31:0] tx_q[$];
  int checks = 0;
  int errors = 0;

  // Monitor: every readdatavalid pulse and every stream handshake pops one expectation.
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rdv got readdatavalid with readdata=%h required no pulse", avs_readdata);
      end else begin
        exp_t e;
        e = rd_q.pop_front();
        if (avs_readdata !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s got readdata=%h at cycle %0d required %h at cycle %0d",
                   e.name, avs_readdata, cyc, e.data, e.cyc);
        end else begin
          $display("PASS %s readdata=%h cycle=%0d", e.name, avs_readdata, cyc);
        end
      end
    end
    if (tx_valid && tx_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tx got tx_data=%h required no word", tx_data);
      end else begin
        logic [31:0] w;
        w = tx_q.pop_front();
        if (tx_data !== w) begin
          errors++;
          $display("FAIL tx_word got %h required %h", tx_data, w);
        end else begin
          $display("PASS tx_word %h", tx_data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, exp);
    end else begin
      $display("PASS %s %h", nm, act);
    end
  endtask

  // Waits (bounded) for waitrequest low, then returns just after the accepting edge.
  task automatic wait_accept(input string nm, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got waitrequest=1 for 50 cycles required 0", nm);
    end
  endtask

  task automatic do_write(input logic [17:0] a, input logic [31:0] d, input logic [3:0] be);
    bit ok;
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    wait_accept("write", ok);
    if (ok && a == 18'h18) tx_q.push_back(d);
    avs_write = 1'b0;
  endtask

  task automatic do_read(input logic [17:0] a, input logic [31:0] exp, input string nm);
    bit ok;
    exp_t e;
    avs_address = a;
    avs_read    = 1'b1;
    wait_accept(nm, ok);
    if (ok) begin
      e.data = exp;
      e.cyc  = cyc;
      e.name = nm;
      rd_q.push_back(e);
    end
    avs_read = 1'b0;
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = 4'hF;
    avs_burstcount = 1'b1; avs_debugaccess = 1'b0;
    irq_src_i = '0; gp_in = '0; tx_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("reset_outputs", {28'd0, avs_readdatavalid, irq_o, tx_valid, |gp_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_read(18'h00, 32'h504C_4B31, "id");
    do_write(18'h04, 32'hFFFF_FFFF, 4'b0101);
    do_read(18'h04, 32'h00FF_00FF, "scratch_be");

    // IRQ: unused enable bits, edge set, W1C racing a new edge, plain W1C.
    do_write(18'h0C, 32'hFFFF_FFFF, 4'hF);
    do_read(18'h0C, 32'h0000_00FF, "en_unused_bits");
    do_write(18'h0C, 32'h0000_0008, 4'hF);
    irq_src_i = 8'h08;
    repeat (3) @(posedge clk);
    #1;
    do_read(18'h08, 32'h0000_0008, "pend_set");
    @(negedge clk);
    chk("irq_o_high", 32'(irq_o), 32'd1);
    @(posedge clk); #1;
    irq_src_i = 8'h00;
    @(posedge clk); #1;
    irq_src_i = 8'h08;
    do_write(18'h08, 32'h0000_0008, 4'hF);
    do_read(18'h08, 32'h0000_0008, "pend_set_beats_w1c");
    do_write(18'h08, 32'h0000_0008, 4'hF);
    do_read(18'h08, 32'h0000_0000, "pend_w1c");
    @(negedge clk);
    chk("irq_o_low", 32'(irq_o), 32'd0);
    @(posedge clk); #1;

    // GP out with byteenable, GP in through the synchroniser.
    do_write(18'h10, 32'hDEAD_BEEF, 4'b1100);
    @(negedge clk);
    chk("gp_out", gp_out, 32'hDEAD_0000);
    @(posedge clk); #1;
    gp_in = 32'hA5A5_0001;
    repeat (3) @(posedge clk);
    #1;
    do_read(18'h14, 32'hA5A5_0001, "gp_in_sync");

    // Decode errors: out-of-map read/write, sticky and its W1C.
    do_read(18'h40, 32'h0, "oob_read");
    do_read(18'h1C, 32'h0002_0200, "txstat_derr");
    do_write(18'h1C, 32'h0002_0000, 4'hF);
    do_read(18'h1C, 32'h0000_0200, "txstat_derr_clr");
    do_write(18'h24, 32'h1111_1111, 4'hF);
    do_read(18'h04, 32'h00FF_00FF, "oob_write_dropped");
    do_write(18'h1C, 32'h0002_0000, 4'hF);

    // Illegal read+write: the write lands, no readdatavalid, decode_err set.
    avs_read = 1'b1;
    do_write(18'h04, 32'h1234_5678, 4'hF);
    avs_read = 1'b0;
    do_read(18'h04, 32'h1234_5678, "rw_write_wins");
    do_read(18'h1C, 32'h0002_0200, "rw_derr");
    do_write(18'h1C, 32'h0002_0000, 4'hF);

    // TX FIFO: fill, stall on the ninth push, drain in order.
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_write(18'h18, 32'hC0DE_0000 + 32'(i), 4'hF);
    do_read(18'h18, 32'h0, "txdata_reads_zero");
    do_read(18'h1C, 32'h0000_0108, "txstat_full");
    avs_address = 18'h18; avs_writedata = 32'hC0DE_0008; avs_write = 1'b1;
    @(negedge clk);
    chk("tx_full_stall", 32'(avs_waitrequest), 32'd1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_accept("ninth_push", ok);
    if (ok) tx_q.push_back(32'hC0DE_0008);
    avs_write = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("tx_drained", 32'(tx_q.size()), 32'd0);
    do_read(18'h1C, 32'h0000_0200, "txstat_empty");

    // Reset one cycle after an accepted read: no readdatavalid, everything cleared.
    avs_address = 18'h00; avs_read = 1'b1;
    @(posedge clk); #1;
    avs_read = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("midreset_rdv", 32'(avs_readdatavalid), 32'd0);
    chk("midreset_gp_out", gp_out, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_read(18'h04, 32'h0, "reset_scratch");
    do_read(18'h0C, 32'h0, "reset_en");
    do_read(18'h10, 32'h0, "reset_gp_out_reg");
    do_read(18'h1C, 32'h0000_0200, "reset_txstat");

    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish required finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
